// File: rtl/layer1_pool_ctrl.sv
// layer1_pool_ctrl: walks the input map in 2x2 windows, fetches four pixels per
// window, hands them to the pooling datapath and writes each pooled pixel out.
module layer1_pool_ctrl #(
  parameter int BITS   = 16,
  parameter int CH     = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 10
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   start,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [CH*BITS-1:0]     rd_data,
  output logic [CH*4*BITS-1:0]   pool_data,
  output logic                   pool_start,
  input  logic [CH*BITS-1:0]     pool_out,
  input  logic                   pool_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [CH*BITS-1:0]     wr_data,
  output logic                   busy,
  output logic                   done
);

  // Integer division floors odd dimensions, so the trailing row/column is never visited.
  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] LAST_R  = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_A = ADDR_W'(OUT_W);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, POOL, WAIT, WRITE, DONE} state_t;

  state_t state_reg, state_next;
  logic [ADDR_W-1:0]  r_reg, r_next;
  logic [ADDR_W-1:0]  c_reg, c_next;
  logic [1:0]         k_reg, k_next;
  logic               rd_en_reg, rd_en_next;
  logic [ADDR_W-1:0]  rd_addr_reg, rd_addr_next;
  logic               pool_start_reg, pool_start_next;
  logic               wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0]  wr_addr_reg, wr_addr_next;
  logic [CH*BITS-1:0] wr_data_reg;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               cap_en;
  logic [1:0]         cap_slot;

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          r_next     = '0;
          c_next     = '0;
          k_next     = 2'd0;
        end
      end
      FETCH: begin
        if (k_reg == 2'd3) state_next = LAST;
        else               k_next     = k_reg + 2'd1;
      end
      LAST:  state_next = POOL;
      POOL:  state_next = WAIT;
      WAIT:  if (pool_ready) state_next = WRITE;
      WRITE: begin
        k_next = 2'd0;
        if (r_reg == LAST_R && c_reg == LAST_C) begin
          state_next = DONE;
          r_next     = '0;
          c_next     = '0;
        end else begin
          state_next = FETCH;
          if (c_reg == LAST_C) begin
            c_next = '0;
            r_next = r_reg + 1'b1;
          end else begin
            c_next = c_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop.
  always_comb begin
    rd_en_next      = (state_next == FETCH);
    pool_start_next = (state_next == POOL);
    wr_en_next      = (state_next == WRITE);
    done_next       = (state_next == DONE);
    busy_next       = (state_next != IDLE) && (state_next != DONE);
    rd_addr_next    = rd_addr_reg;
    wr_addr_next    = wr_addr_reg;
    if (state_next == FETCH)
      rd_addr_next = ((r_next << 1) + ADDR_W'(k_next[1])) * IMG_W_A
                     + (c_next << 1) + ADDR_W'(k_next[0]);
    if (state_next == WRITE)
      wr_addr_next = r_reg * OUT_W_A + c_reg;
  end

  // Read data trails rd_en by one cycle: FETCH slot k stores pixel k-1, LAST stores pixel 3.
  always_comb begin
    cap_en   = ((state_reg == FETCH) && (k_reg != 2'd0)) || (state_reg == LAST);
    cap_slot = (state_reg == LAST) ? 2'd3 : (k_reg - 2'd1);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg      <= IDLE;
      r_reg          <= '0;
      c_reg          <= '0;
      k_reg          <= 2'd0;
      rd_en_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      pool_start_reg <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      r_reg          <= r_next;
      c_reg          <= c_next;
      k_reg          <= k_next;
      rd_en_reg      <= rd_en_next;
      rd_addr_reg    <= rd_addr_next;
      pool_start_reg <= pool_start_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      if (state_reg == WAIT && pool_ready)
        wr_data_reg <= pool_out;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_chan
      logic [4*BITS-1:0] win_reg;
      always_ff @(posedge clk_in) begin
        if (rst)
          win_reg <= '0;
        else if (cap_en)
          win_reg[cap_slot*BITS +: BITS] <= rd_data[gi*BITS +: BITS];
      end
      assign pool_data[gi*4*BITS +: 4*BITS] = win_reg;
    end
  endgenerate

  assign rd_en      = rd_en_reg;
  assign rd_addr    = rd_addr_reg;
  assign pool_start = pool_start_reg;
  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_layer1_pool_ctrl.sv
// Bench for layer1_pool_ctrl: a 4x4 instance and a 5x5 instance, each with a
// ramp input RAM and a max-pooling datapath model with programmable latency.
module tb_layer1_pool_ctrl;

  localparam int BITS = 8;
  localparam int CH   = 2;
  localparam int AW   = 10;
  localparam int W_A  = 4;
  localparam int W_B  = 5;
  localparam int PW   = CH*BITS;
  localparam int WW   = CH*4*BITS;
  localparam int RW   = AW + PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance A (4x4) ----------------
  logic          rst_a = 1'b1, start_a = 1'b0;
  logic          rd_en_a, pool_start_a, wr_en_a, busy_a, done_a, pool_ready_a;
  logic [AW-1:0] rd_addr_a, wr_addr_a;
  logic [PW-1:0] rd_data_a = '0, pool_out_a = '0, wr_data_a;
  logic [WW-1:0] pool_data_a;

  layer1_pool_ctrl #(.BITS(BITS), .CH(CH), .IMG_W(W_A), .IMG_H(W_A), .ADDR_W(AW)) dut_a (
    .clk_in(clk), .rst(rst_a), .start(start_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .pool_data(pool_data_a), .pool_start(pool_start_a),
    .pool_out(pool_out_a), .pool_ready(pool_ready_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B (5x5) ----------------
  logic          rst_b = 1'b1, start_b = 1'b0;
  logic          rd_en_b, pool_start_b, wr_en_b, busy_b, done_b;
  logic          pool_ready_b = 1'b0;
  logic [AW-1:0] rd_addr_b, wr_addr_b;
  logic [PW-1:0] rd_data_b = '0, pool_out_b = '0, wr_data_b;
  logic [WW-1:0] pool_data_b;

  layer1_pool_ctrl #(.BITS(BITS), .CH(CH), .IMG_W(W_B), .IMG_H(W_B), .ADDR_W(AW)) dut_b (
    .clk_in(clk), .rst(rst_b), .start(start_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .pool_data(pool_data_b), .pool_start(pool_start_b),
    .pool_out(pool_out_b), .pool_ready(pool_ready_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .done(done_b)
  );

  // Ramp image: pixel n carries n in channel 0 and n+64*i in channel i.
  function automatic logic [PW-1:0] pix(input int addr);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*BITS +: BITS] = BITS'(addr + 64*i);
    return v;
  endfunction

  function automatic logic [PW-1:0] maxwin(input logic [WW-1:0] w);
    logic [PW-1:0] v;
    logic [BITS-1:0] m;
    v = '0;
    for (int i = 0; i < CH; i++) begin
      m = '0;
      for (int k = 0; k < 4; k++)
        if (w[i*4*BITS + k*BITS +: BITS] > m) m = w[i*4*BITS + k*BITS +: BITS];
      v[i*BITS +: BITS] = m;
    end
    return v;
  endfunction

  function automatic int exp_rd(input int w, input int r, input int c, input int k);
    return (2*r + k/2)*w + 2*c + (k%2);
  endfunction

  function automatic logic [WW-1:0] expwin(input int w, input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < CH; i++)
        v[i*4*BITS + k*BITS +: BITS] = BITS'(exp_rd(w, r, c, k) + 64*i);
    return v;
  endfunction

  // On a ramp the bottom-right pixel is the window maximum.
  function automatic logic [RW-1:0] exp_wr(input int w, input int r, input int c);
    return {AW'(r*(w/2) + c), pix((2*r + 1)*w + 2*c + 1)};
  endfunction

  // RAM and datapath models for A
  int   dly_a = 1;
  int   cnt_a = 0;
  logic rdy_m_a = 1'b0;
  logic spur_a  = 1'b0;
  assign pool_ready_a = rdy_m_a | spur_a;

  always @(posedge clk) if (rd_en_a) rd_data_a <= pix(int'(rd_addr_a));

  always @(posedge clk) begin
    rdy_m_a <= 1'b0;
    if (pool_start_a) begin
      pool_out_a <= maxwin(pool_data_a);
      if (dly_a <= 1) rdy_m_a <= 1'b1;
      else            cnt_a   <= dly_a - 1;
    end else if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) rdy_m_a <= 1'b1;
    end
  end

  // RAM and 1-cycle datapath models for B
  always @(posedge clk) begin
    if (rd_en_b) rd_data_b <= pix(int'(rd_addr_b));
    pool_ready_b <= pool_start_b;
    if (pool_start_b) pool_out_b <= maxwin(pool_data_b);
  end

  // Monitors and scoreboards
  logic [RW-1:0] exp_q[$], obs_q[$], exp_qb[$], obs_qb[$];
  int rdq_a[$], rdq_b[$];
  int done_n_a = 0, ps_n_a = 0, done_n_b = 0;

  always @(negedge clk) begin
    if (wr_en_a)      obs_q.push_back({wr_addr_a, wr_data_a});
    if (rd_en_a)      rdq_a.push_back(int'(rd_addr_a));
    if (done_a)       done_n_a++;
    if (pool_start_a) ps_n_a++;
    if (wr_en_b)      obs_qb.push_back({wr_addr_b, wr_data_b});
    if (rd_en_b)      rdq_b.push_back(int'(rd_addr_b));
    if (done_b)       done_n_b++;
  end

  task automatic clr_a();
    exp_q.delete(); obs_q.delete(); rdq_a.delete();
    done_n_a = 0; ps_n_a = 0;
  endtask

  task automatic push_exp_a();
    for (int r = 0; r < W_A/2; r++)
      for (int c = 0; c < W_A/2; c++) exp_q.push_back(exp_wr(W_A, r, c));
  endtask

  task automatic start_pulse_a(output int c0);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done_a(input int budget, output int dc, output logic bz);
    dc = -1; bz = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin dc = cyc; bz = busy_a; break; end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_en_a, pool_start_a, wr_en_a, done_a, busy_a} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {rd_en_a, pool_start_a, wr_en_a, done_a, busy_a});
    end
    n_checks++;
    if ({rd_addr_a, wr_addr_a} !== '0) begin
      n_fail++; $display("FAIL reset_addr: got rd=%0d wr=%0d expected 0", rd_addr_a, wr_addr_a);
    end
    n_checks++;
    if ({pool_data_a, wr_data_a} !== '0) begin
      n_fail++; $display("FAIL reset_data: got pool=%h wr=%h expected 0", pool_data_a, wr_data_a);
    end
    n_checks++;
    if ({rd_en_b, pool_start_b, wr_en_b, done_b, busy_b, rd_addr_b, wr_addr_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs not zero");
    end
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({rd_en_a, pool_start_a, wr_en_a, done_a, busy_a} !== 5'b0) begin
      n_fail++; $display("FAIL idle_strobes: got %b expected 00000", {rd_en_a, pool_start_a, wr_en_a, done_a, busy_a});
    end
    $display("test_reset done");
  endtask

  task automatic test_full_run();
    int c0, dc, tr[4];
    logic bz;
    logic [RW-1:0] e, o;
    tr = '{2, 3, 6, 7};
    clr_a(); push_exp_a();
    start_pulse_a(c0);
    wait_done_a(200, dc, bz);
    repeat (3) @(negedge clk);
    n_checks++;
    if (dc - c0 != 32) begin
      n_fail++; $display("FAIL run_latency: got %0d expected 32 (dc=%0d)", dc - c0, dc);
    end
    n_checks++;
    if (bz !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", bz); end
    n_checks++;
    if (done_n_a != 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", done_n_a); end
    n_checks++;
    if (ps_n_a != 4) begin n_fail++; $display("FAIL pool_start_count: got %0d expected 4", ps_n_a); end
    n_checks++;
    if (rdq_a.size() != 16) begin
      n_fail++; $display("FAIL rd_count: got %0d expected 16", rdq_a.size());
    end else begin
      for (int n = 0; n < 16; n++) begin
        n_checks++;
        if (rdq_a[n] != exp_rd(W_A, (n/4)/2, (n/4)%2, n%4)) begin
          n_fail++; $display("FAIL rd_addr[%0d]: got %0d expected %0d", n, rdq_a[n], exp_rd(W_A, (n/4)/2, (n/4)%2, n%4));
        end
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rdq_a[4+k] != tr[k]) begin
          n_fail++; $display("FAIL trace_r0c1[%0d]: got %0d expected %0d", k, rdq_a[4+k], tr[k]);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL write: got %h expected %h", o, e); end
      else $display("write addr=%0d data=%h ok", o[RW-1 -: AW], o[PW-1:0]);
    end
    $display("test_full_run done");
  endtask

  task automatic test_slow_ready();
    int c0, dc, ps, unstable, rdy1, wr1, wr2;
    logic in_win, got0;
    logic [WW-1:0] snap, snap0;
    logic [RW-1:0] e, o;
    ps = 0; unstable = 0; rdy1 = -1; wr1 = -1; wr2 = -1; dc = -1;
    in_win = 1'b0; got0 = 1'b0; snap = '0; snap0 = '0;
    dly_a = 5;
    clr_a(); push_exp_a();
    start_pulse_a(c0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pool_start_a) begin
        ps++; snap = pool_data_a; in_win = 1'b1;
        if (!got0) begin snap0 = pool_data_a; got0 = 1'b1; end
      end
      if (in_win && pool_data_a !== snap) unstable++;
      if (pool_ready_a && rdy1 < 0) rdy1 = cyc;
      if (wr_en_a) begin
        in_win = 1'b0;
        if (wr1 < 0) wr1 = cyc; else if (wr2 < 0) wr2 = cyc;
      end
      if (done_a) begin dc = cyc; break; end
    end
    repeat (2) @(negedge clk);
    dly_a = 1;
    n_checks++;
    if (ps != 4) begin n_fail++; $display("FAIL slow_pool_start: got %0d expected 4", ps); end
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL pool_data_stable: got %0d changes expected 0", unstable); end
    n_checks++;
    if (snap0 !== expwin(W_A, 0, 0)) begin
      n_fail++; $display("FAIL pool_data_pack: got %h expected %h", snap0, expwin(W_A, 0, 0));
    end
    n_checks++;
    if (wr1 - rdy1 != 1) begin n_fail++; $display("FAIL ready_to_write: got %0d expected 1", wr1 - rdy1); end
    n_checks++;
    if (wr2 - wr1 != 12) begin n_fail++; $display("FAIL window_cycles: got %0d expected 12", wr2 - wr1); end
    n_checks++;
    if (dc - c0 != 48) begin n_fail++; $display("FAIL slow_latency: got %0d expected 48", dc - c0); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL slow_write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL slow_write: got %h expected %h", o, e); end
      else $display("slow write addr=%0d data=%h ok", o[RW-1 -: AW], o[PW-1:0]);
    end
    $display("test_slow_ready done");
  endtask

  task automatic test_ignore();
    int c0, dc;
    logic bz, busy_at;
    logic [RW-1:0] e, o;
    busy_at = 1'b0;
    clr_a(); push_exp_a();
    start_pulse_a(c0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_en_a && cyc >= c0 + 9) break;
    end
    busy_at = busy_a;
    spur_a = 1'b1; start_a = 1'b1;
    @(negedge clk) spur_a = 1'b0; start_a = 1'b0;
    wait_done_a(200, dc, bz);
    repeat (12) @(negedge clk);
    n_checks++;
    if (busy_at !== 1'b1) begin n_fail++; $display("FAIL busy_mid_run: got %b expected 1", busy_at); end
    n_checks++;
    if (dc - c0 != 32) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 32", dc - c0); end
    n_checks++;
    if (done_n_a != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_n_a); end
    n_checks++;
    if (obs_q.size() != 4) begin n_fail++; $display("FAIL ignore_write_count: got %0d expected 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL ignore_write: got %h expected %h", o, e); end
      else $display("ignore write addr=%0d data=%h ok", o[RW-1 -: AW], o[PW-1:0]);
    end
    $display("test_ignore done");
  endtask

  task automatic test_reset_mid();
    int c0, dc, nw;
    logic bz;
    logic [RW-1:0] e, o;
    nw = 0;
    clr_a();
    start_pulse_a(c0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_en_a) nw++;
      if (nw == 2) break;
    end
    rst_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rd_en_a, pool_start_a, wr_en_a, done_a, busy_a} !== 5'b0) begin
      n_fail++; $display("FAIL midrst_strobes: got %b expected 00000", {rd_en_a, pool_start_a, wr_en_a, done_a, busy_a});
    end
    n_checks++;
    if ({rd_addr_a, wr_addr_a, pool_data_a, wr_data_a} !== '0) begin
      n_fail++; $display("FAIL midrst_data: got rd=%0d wr=%0d wd=%h expected 0", rd_addr_a, wr_addr_a, wr_data_a);
    end
    rst_a = 1'b0; start_a = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_over_start: got busy=%b expected 0", busy_a); end
    n_checks++;
    if (obs_q.size() != 2) begin n_fail++; $display("FAIL midrst_writes: got %0d expected 2", obs_q.size()); end
    clr_a(); push_exp_a();
    start_pulse_a(c0);
    wait_done_a(200, dc, bz);
    repeat (3) @(negedge clk);
    n_checks++;
    if (dc - c0 != 32) begin n_fail++; $display("FAIL rerun_latency: got %0d expected 32", dc - c0); end
    n_checks++;
    if (obs_q.size() != 4) begin n_fail++; $display("FAIL rerun_write_count: got %0d expected 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rerun_write: got %h expected %h", o, e); end
      else $display("rerun write addr=%0d data=%h ok", o[RW-1 -: AW], o[PW-1:0]);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_odd_size();
    int c0, dc, bad;
    logic bz;
    logic [RW-1:0] e, o;
    dc = -1; bz = 1'bx; bad = 0;
    exp_qb.delete(); obs_qb.delete(); rdq_b.delete(); done_n_b = 0;
    for (int r = 0; r < W_B/2; r++)
      for (int c = 0; c < W_B/2; c++) exp_qb.push_back(exp_wr(W_B, r, c));
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_b) begin dc = cyc; bz = busy_b; break; end
    end
    repeat (3) @(negedge clk);
    foreach (rdq_b[n]) if (rdq_b[n] / W_B == 4 || rdq_b[n] % W_B == 4) bad++;
    n_checks++;
    if (dc - c0 != 32) begin n_fail++; $display("FAIL odd_latency: got %0d expected 32", dc - c0); end
    n_checks++;
    if (rdq_b.size() != 16) begin n_fail++; $display("FAIL odd_rd_count: got %0d expected 16", rdq_b.size()); end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL odd_edge_reads: got %0d expected 0", bad); end
    n_checks++;
    if (done_n_b != 1) begin n_fail++; $display("FAIL odd_done_count: got %0d expected 1", done_n_b); end
    n_checks++;
    if (obs_qb.size() != 4) begin n_fail++; $display("FAIL odd_write_count: got %0d expected 4", obs_qb.size()); end
    while (exp_qb.size() > 0 && obs_qb.size() > 0) begin
      e = exp_qb.pop_front(); o = obs_qb.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL odd_write: got %h expected %h", o, e); end
      else $display("odd write addr=%0d data=%h ok", o[RW-1 -: AW], o[PW-1:0]);
    end
    $display("test_odd_size done");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_slow_ready();
    test_ignore();
    test_reset_mid();
    test_odd_size();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
